dispatch: RTL and testbench

- Stage directly downstream of rename. Consumes one renamed instruction per cycle (rename_data).
- Allocates the instruction's ROB entry and sends it to exactly one reservation station: ALU, branch or memory.
- Holds a 128-entry physical-register busy table so each dispatched operand carries a ready bit.
- Operand ready bits are snooped from the writeback bus while an instruction waits in the stage.

---
 rtl/types_pkg.sv | 53 +++++
 rtl/busy_table.sv | 36 +++
 rtl/dispatch.sv | 107 ++++++++++
 tb/tb_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the dispatch stage: renamed instruction, RS payload,
// ROB allocation payload and the reservation-station target encoding.
package types_pkg;

  localparam int PREG_COUNT = 128;
  localparam int PREG_W     = 7;
  localparam int ROB_TAG_W  = 4;
  localparam int PC_W       = 32;

  // Physical register 0 is the hardwired-zero register: never busy.
  localparam logic [PREG_W-1:0] PREG_ZERO = '0;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_ALU  = 2'd1,
    RS_BR   = 2'd2,
    RS_MEM  = 2'd3
  } rs_sel_e;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 fu_alu;
    logic                 fu_br;
    logic                 fu_mem;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
  } rename_data;

  typedef struct packed {
    rename_data inst;
    logic       ps1_rdy;
    logic       ps2_rdy;
  } dispatch_data;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
  } rob_alloc_data;

  // fu_* is one-hot; an instruction with no fu bit set goes to the ALU.
  function automatic rs_sel_e rs_target(input rename_data d);
    if (d.fu_alu)      return RS_ALU;
    else if (d.fu_br)  return RS_BR;
    else if (d.fu_mem) return RS_MEM;
    else               return RS_ALU;
  endfunction

endpackage

// File: rtl/busy_table.sv
// Physical-register busy table. One set port (allocation), one clear port
// (writeback), two combinational read ports that see a same-cycle writeback.
module busy_table
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [PREG_W-1:0] set_pd,
  input  logic              clr_en,
  input  logic [PREG_W-1:0] clr_pd,
  input  logic [PREG_W-1:0] rd1_pd,
  output logic              rd1_rdy,
  input  logic [PREG_W-1:0] rd2_pd,
  output logic              rd2_rdy
);

  logic [PREG_COUNT-1:0] busy_q;

  // Clear then set: the later non-blocking write wins, so set beats clear
  // on the same index. Register 0 is never written and stays ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      if (clr_en && (clr_pd != PREG_ZERO)) busy_q[clr_pd] <= 1'b0;
      if (set_en && (set_pd != PREG_ZERO)) busy_q[set_pd] <= 1'b1;
    end
  end

  assign rd1_rdy = (rd1_pd == PREG_ZERO) || !busy_q[rd1_pd] ||
                   (clr_en && (clr_pd == rd1_pd));
  assign rd2_rdy = (rd2_pd == PREG_ZERO) || !busy_q[rd2_pd] ||
                   (clr_en && (clr_pd == rd2_pd));

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: one-entry holding register between rename and the ROB /
// reservation stations, with operand ready bits from a busy table and
// writeback snooping while the instruction waits.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the clock edge. A producer holds valid and payload stable until
// the transfer; ready never depends combinationally on the matching valid.
// The ROB and the selected RS always transfer together (fire), never alone.
module dispatch
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  rename_data        data_in,
  output logic              ready_in,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_pd,
  input  logic              mispredict,
  output logic              rob_valid,
  input  logic              rob_ready,
  output rob_alloc_data     rob_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic              br_valid,
  input  logic              br_ready,
  output logic              mem_valid,
  input  logic              mem_ready,
  output dispatch_data      rs_data
);

  dispatch_data held_q;
  logic         valid_h;
  rs_sel_e      tgt;
  logic         sel_ready;
  logic         fire;
  logic         accept;
  logic         ps1_rdy_in;
  logic         ps2_rdy_in;

  assign tgt = rs_target(held_q.inst);

  // Ready of the reservation station this entry is headed for.
  always_comb begin
    sel_ready = alu_ready;
    case (tgt)
      RS_BR:   sel_ready = br_ready;
      RS_MEM:  sel_ready = mem_ready;
      default: sel_ready = alu_ready;
    endcase
  end

  assign fire     = valid_h && rob_ready && sel_ready;
  assign ready_in = (!valid_h || fire) && !mispredict;
  assign accept   = valid_in && ready_in;

  // Each side only asserts valid when the other side can also take it.
  assign rob_valid = valid_h && sel_ready;
  assign alu_valid = valid_h && (tgt == RS_ALU) && rob_ready;
  assign br_valid  = valid_h && (tgt == RS_BR)  && rob_ready;
  assign mem_valid = valid_h && (tgt == RS_MEM) && rob_ready;

  assign rs_data = held_q;

  // ROB allocation payload is a view of the held instruction.
  always_comb begin
    rob_data         = '0;
    rob_data.pc      = held_q.inst.pc;
    rob_data.rob_tag = held_q.inst.rob_tag;
    rob_data.pd_new  = held_q.inst.pd_new;
    rob_data.pd_old  = held_q.inst.pd_old;
  end

  busy_table u_busy (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept),
    .set_pd  (data_in.pd_new),
    .clr_en  (wb_valid),
    .clr_pd  (wb_pd),
    .rd1_pd  (data_in.ps1),
    .rd1_rdy (ps1_rdy_in),
    .rd2_pd  (data_in.ps2),
    .rd2_rdy (ps2_rdy_in)
  );

  // Holding register: load on accept, drop on fire or flush, snoop writeback
  // into the sticky ready bits while the entry waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q  <= '0;
      valid_h <= 1'b0;
    end else if (accept) begin
      held_q.inst    <= data_in;
      held_q.ps1_rdy <= ps1_rdy_in;
      held_q.ps2_rdy <= ps2_rdy_in;
      valid_h        <= 1'b1;
    end else begin
      if (fire || mispredict) valid_h <= 1'b0;
      if (valid_h && wb_valid) begin
        if (wb_pd == held_q.inst.ps1) held_q.ps1_rdy <= 1'b1;
        if (wb_pd == held_q.inst.ps2) held_q.ps2_rdy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for the dispatch stage: expected hand-offs are queued by the
// driver and compared by a negedge monitor whenever ROB and RS both transfer.
module tb_dispatch;
  import types_pkg::*;

  localparam int W = 2 + 32 + 4 + 7 + 7 + 1 + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              valid_in;
  rename_data        data_in;
  logic              ready_in;
  logic              wb_valid;
  logic [PREG_W-1:0] wb_pd;
  logic              mispredict;
  logic              rob_valid;
  logic              rob_ready;
  rob_alloc_data     rob_data;
  logic              alu_valid;
  logic              alu_ready;
  logic              br_valid;
  logic              br_ready;
  logic              mem_valid;
  logic              mem_ready;
  dispatch_data      rs_data;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  dispatch dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_in   (ready_in),
    .wb_valid   (wb_valid),
    .wb_pd      (wb_pd),
    .mispredict (mispredict),
    .rob_valid  (rob_valid),
    .rob_ready  (rob_ready),
    .rob_data   (rob_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .rs_data    (rs_data)
  );

  // fu: 0 none, 1 alu, 2 br, 3 mem
  function automatic rename_data mk(input logic [31:0] pc, input logic [3:0] tag,
                                    input logic [1:0] fu, input logic [6:0] ps1,
                                    input logic [6:0] ps2, input logic [6:0] pd_new,
                                    input logic [6:0] pd_old);
    rename_data d;
    d         = '0;
    d.pc      = pc;
    d.rob_tag = tag;
    d.fu_alu  = (fu == 2'd1);
    d.fu_br   = (fu == 2'd2);
    d.fu_mem  = (fu == 2'd3);
    d.ps1     = ps1;
    d.ps2     = ps2;
    d.pd_new  = pd_new;
    d.pd_old  = pd_old;
    return d;
  endfunction

  // rs code observed: 1 alu, 2 br, 3 mem
  task automatic expect_txn(input logic [1:0] rs, input logic [31:0] pc,
                            input logic [3:0] tag, input logic [6:0] pd_new,
                            input logic [6:0] pd_old, input logic r1, input logic r2);
    exp_q.push_back({rs, pc, tag, pd_new, pd_old, r1, r2});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic         rob_take;
    logic         rs_take;
    logic [1:0]   code;
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    if (reset) begin
      rob_take = rob_valid && rob_ready;
      rs_take  = (alu_valid && alu_ready) || (br_valid && br_ready) ||
                 (mem_valid && mem_ready);
      total++;
      if (rob_take !== rs_take) begin
        bad++;
        $display("FAIL handshake_pair: rob_take %0b rs_take %0b", rob_take, rs_take);
      end
      if (rob_take) begin
        code = 2'd0;
        if (alu_valid && !br_valid && !mem_valid) code = 2'd1;
        if (!alu_valid && br_valid && !mem_valid) code = 2'd2;
        if (!alu_valid && !br_valid && mem_valid) code = 2'd3;
        obs = {code, rob_data.pc, rob_data.rob_tag, rob_data.pd_new, rob_data.pd_old,
               rs_data.ps1_rdy, rs_data.ps2_rdy};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL dispatch_txn: got %0h want nothing", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL dispatch_txn: got %0h want %0h", obs, exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // driver
  initial begin
    valid_in   = 1'b0;
    data_in    = '0;
    wb_valid   = 1'b0;
    wb_pd      = '0;
    mispredict = 1'b0;
    rob_ready  = 1'b1;
    alu_ready  = 1'b1;
    br_ready   = 1'b1;
    mem_ready  = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_rob_valid", rob_valid, 0);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_rs_data", rs_data, 0);
    check("rst_rob_data", rob_data, 0);
    check("rst_ready_in", ready_in, 1);
    cyc();
    reset = 1'b1;

    // single ALU op, sources idle
    data_in = mk(32'h100, 4'd0, 2'd1, 7'd5, 7'd6, 7'd40, 7'd3);
    valid_in = 1'b1;
    expect_txn(2'd1, 32'h100, 4'd0, 7'd40, 7'd3, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_ready_in", ready_in, 1);
    cyc();
    valid_in = 1'b0;
    @(negedge clk);
    check("t1_alu_valid", alu_valid, 1);
    check("t1_rdy_bits", {rs_data.ps1_rdy, rs_data.ps2_rdy}, 2'b11);
    cyc();

    // consumer of p40 stalls on alu_ready, snoops the writeback
    data_in = mk(32'h104, 4'd1, 2'd1, 7'd40, 7'd0, 7'd41, 7'd4);
    valid_in = 1'b1;
    expect_txn(2'd1, 32'h104, 4'd1, 7'd41, 7'd4, 1'b1, 1'b1);
    @(negedge clk);
    cyc();
    valid_in = 1'b0;
    alu_ready = 1'b0;
    @(negedge clk);
    check("t2_alu_valid_stall", alu_valid, 1);
    check("t2_rob_valid_stall", rob_valid, 0);
    check("t2_ready_in_stall", ready_in, 0);
    check("t2_rdy_bits", {rs_data.ps1_rdy, rs_data.ps2_rdy}, 2'b01);
    cyc();
    wb_valid = 1'b1;
    wb_pd = 7'd40;
    @(negedge clk);
    check("t2_ps1_before_snoop", rs_data.ps1_rdy, 0);
    cyc();
    wb_valid = 1'b0;
    @(negedge clk);
    check("t2_ps1_after_snoop", rs_data.ps1_rdy, 1);
    check("t2_rob_valid_still", rob_valid, 0);
    cyc();
    alu_ready = 1'b1;
    @(negedge clk);
    check("t2_rob_valid_go", rob_valid, 1);
    cyc();

    // p40 is free again; p7 allocated then bypassed at the consumer's accept
    data_in = mk(32'h108, 4'd2, 2'd1, 7'd40, 7'd0, 7'd7, 7'd5);
    valid_in = 1'b1;
    expect_txn(2'd1, 32'h108, 4'd2, 7'd7, 7'd5, 1'b1, 1'b1);
    @(negedge clk);
    cyc();
    data_in = mk(32'h10c, 4'd3, 2'd1, 7'd41, 7'd7, 7'd8, 7'd6);
    wb_valid = 1'b1;
    wb_pd = 7'd7;
    expect_txn(2'd1, 32'h10c, 4'd3, 7'd8, 7'd6, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_ready_in_on_fire", ready_in, 1);
    cyc();
    valid_in = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    check("t3_rdy_bits", {rs_data.ps1_rdy, rs_data.ps2_rdy}, 2'b01);
    cyc();

    // branch waits on the ROB
    data_in = mk(32'h200, 4'd4, 2'd2, 7'd0, 7'd0, 7'd0, 7'd0);
    valid_in = 1'b1;
    expect_txn(2'd2, 32'h200, 4'd4, 7'd0, 7'd0, 1'b1, 1'b1);
    @(negedge clk);
    cyc();
    valid_in = 1'b0;
    rob_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_br_valid_wait", br_valid, 0);
      check("t4_rob_valid_wait", rob_valid, 1);
      check("t4_ready_in_wait", ready_in, 0);
      cyc();
    end
    rob_ready = 1'b1;
    @(negedge clk);
    check("t4_br_valid_go", br_valid, 1);
    check("t4_rob_valid_go", rob_valid, 1);
    check("t4_ready_in_go", ready_in, 1);
    cyc();

    // store stalls on mem_ready, then is flushed
    data_in = mk(32'h300, 4'd5, 2'd3, 7'd8, 7'd41, 7'd0, 7'd0);
    valid_in = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    cyc();
    valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_mem_valid_stall", mem_valid, 1);
      check("t5_rob_valid_stall", rob_valid, 0);
      check("t5_ready_in_stall", ready_in, 0);
      check("t5_held_pc", rs_data.inst.pc, 32'h300);
      check("t5_rdy_bits", {rs_data.ps1_rdy, rs_data.ps2_rdy}, 2'b00);
      cyc();
    end
    mispredict = 1'b1;
    valid_in = 1'b1;
    data_in = mk(32'h304, 4'd6, 2'd1, 7'd0, 7'd0, 7'd9, 7'd1);
    @(negedge clk);
    check("t5_ready_in_flush", ready_in, 0);
    cyc();
    mispredict = 1'b0;
    valid_in = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("t5_rob_valid_after", rob_valid, 0);
    check("t5_mem_valid_after", mem_valid, 0);
    check("t5_ready_in_after", ready_in, 1);
    cyc();

    // four back-to-back ALU ops (last one has no fu bit); p8 still busy
    for (int k = 0; k < 4; k++) begin
      data_in = mk(32'h400 + 32'(4 * k), 4'(k), (k == 3) ? 2'd0 : 2'd1, 7'd8,
                   (k == 0) ? 7'd0 : 7'(50 + k - 1), 7'(50 + k), 7'(20 + k));
      valid_in = 1'b1;
      expect_txn(2'd1, 32'h400 + 32'(4 * k), 4'(k), 7'(50 + k), 7'(20 + k),
                 1'b0, (k == 0));
      @(negedge clk);
      check("t6_ready_in", ready_in, 1);
      if (k > 0) check("t6_alu_valid", alu_valid, 1);
      cyc();
    end
    valid_in = 1'b0;
    @(negedge clk);
    check("t6_alu_valid_last", alu_valid, 1);
    cyc();
    @(negedge clk);
    check("t6_alu_valid_idle", alu_valid, 0);
    check("t6_rob_valid_idle", rob_valid, 0);
    cyc();

    repeat (2) cyc();
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
